// File: rtl/chk_frame_pkg.sv
// chk_frame_pkg
// Shared types and helpers for the checksum framing stages. The transmit
// packer uses it now, and a receive-side checker can reuse it later.
//   state_t     : packer FSM states
//   BYTE_W      : width of a stream byte
//   SOF_DEFAULT : default start-of-frame header byte
//   chk_byte()  : byte that brings a running payload sum to 0 mod 256
package chk_frame_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    PAY,
    CHK,
    WAIT_OUT,
    DROP
  } state_t;

  // Two's complement of the running sum. Payload plus this byte wraps to 0.
  function automatic logic [BYTE_W-1:0] chk_byte(input logic [BYTE_W-1:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/chk_frame_packer.sv
// chk_frame_packer
// Wraps a valid/last byte stream into frames of the form
// SOF, payload..., checksum. The checksum makes the payload plus checksum
// sum to 0 mod 256. Payloads longer than MAX_LEN are cut at MAX_LEN and
// closed with a checksum. The rest of that input frame is then discarded.
// Ports:
//   clk, nrst              : clock (rising edge), async active-low reset
//   in_valid/in_data/in_last/in_ready     : input byte stream
//   out_valid/out_data/out_last/out_ready : framed output, one register stage
//   err_overlen            : one-cycle pulse when a frame is truncated
//   frame_cnt              : frames whose checksum byte was accepted (wraps)
module chk_frame_packer
  import chk_frame_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SOF_BYTE = SOF_DEFAULT,
  parameter int                MAX_LEN  = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err_overlen,
  output logic [7:0]        frame_cnt
);

  // len holds the number of payload bytes already taken. The byte being
  // accepted is the last one allowed when len equals MAX_LEN-1.
  localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

  state_t            state;
  state_t            next_state;
  logic [BYTE_W-1:0] sum;
  logic [7:0]        len;
  logic              trunc;
  logic              free;
  logic              in_fire;
  logic              out_fire;
  logic              at_max;

  assign free     = !out_valid || out_ready;
  assign out_fire = out_valid && out_ready;
  assign in_fire  = in_valid && in_ready;
  assign at_max   = (len == LEN_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The PAY and DROP acceptance terms use in_valid and free directly, so
  // this block never reads back its own in_ready output.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && free) next_state = PAY;
      end
      PAY: begin
        in_ready = free;
        if (in_valid && free && (in_last || at_max)) next_state = CHK;
      end
      CHK: begin
        if (free) next_state = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (out_fire) next_state = trunc ? DROP : IDLE;
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // When nothing new is loaded, a transferred byte simply empties the
  // output register. A load in the same cycle overrides that.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      err_overlen <= 1'b0;
      frame_cnt   <= '0;
      sum         <= '0;
      len         <= '0;
      trunc       <= 1'b0;
    end else begin
      err_overlen <= 1'b0;
      if (out_fire) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && free) begin
            out_valid <= 1'b1;
            out_data  <= SOF_BYTE;
            out_last  <= 1'b0;
            sum       <= '0;
            len       <= '0;
            trunc     <= 1'b0;
          end
        end
        PAY: begin
          if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= 1'b0;
            sum       <= sum + in_data;
            len       <= len + 8'd1;
            if (at_max && !in_last) begin
              trunc       <= 1'b1;
              err_overlen <= 1'b1;
            end
          end
        end
        CHK: begin
          if (free) begin
            out_valid <= 1'b1;
            out_data  <= chk_byte(sum);
            out_last  <= 1'b1;
          end
        end
        WAIT_OUT: begin
          if (out_fire) frame_cnt <= frame_cnt + 8'd1;
        end
        DROP: begin
          if (in_fire && in_last) trunc <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chk_frame_packer.sv
// tb_chk_frame_packer
// Directed bench for chk_frame_packer, built with MAX_LEN=4 so that the
// truncation boundary is easy to reach. A frame-level model turns each
// input payload into the expected output bytes. One negedge process checks
// every output transfer and every stalled cycle against that model. The
// directed tests also compare the collected bytes against literal lists.
`timescale 1ns/1ps
module tb_chk_frame_packer;

  localparam int         MAX_LEN = 4;
  localparam logic [7:0] SOF     = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       err_overlen;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];
  logic [7:0] got_q[$];
  int         modelCount = 0;
  int         expErr = 0;
  int         errSeen = 0;
  int         readyMode = 0;

  logic       holdPend = 1'b0;
  logic [7:0] holdData = 8'h00;
  logic       holdLast = 1'b0;

  chk_frame_packer #(.SOF_BYTE(SOF), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .err_overlen(err_overlen),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Mode 0 keeps out_ready high. Mode 1 repeats the pattern 1,0,0,1.
  // Mode 2 holds out_ready low.
  initial begin
    int ph;
    logic [3:0] pat;
    ph  = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[ph % 4];
          ph++;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // This process checks each transfer against the model and checks that
  // a stalled byte stays stable.
  always @(negedge clk) begin
    if (!nrst) begin
      holdPend = 1'b0;
    end else begin
      if (holdPend) begin
        total++;
        if (!out_valid || out_data !== holdData || out_last !== holdLast) begin
          bad++;
          $display("[TB] FAIL hold: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                   out_valid, out_data, out_last, holdData, holdLast);
        end
      end
      holdPend = out_valid && !out_ready;
      holdData = out_data;
      holdLast = out_last;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL stream: got unexpected byte %0h last=%0b want none", out_data, out_last);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            bad++;
            $display("[TB] FAIL stream: got last=%0b data=%0h want last=%0b data=%0h",
                     out_last, out_data, e[8], e[7:0]);
          end
        end
        got_q.push_back(out_data);
      end
      if (err_overlen) errSeen++;
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("[TB] FAIL in_handshake: got no in_ready after %0d cycles want accept", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // The frame model: SOF, then at most MAX_LEN payload bytes, then the
  // byte that makes the kept payload sum to 0 mod 256. Bytes past MAX_LEN
  // are dropped and the frame raises one error pulse.
  task automatic sendFrame(input bq_t payload);
    int n;
    int kept;
    int s;
    n    = payload.size();
    kept = (n > MAX_LEN) ? MAX_LEN : n;
    s    = 0;
    exp_q.push_back({1'b0, SOF});
    for (int i = 0; i < kept; i++) begin
      exp_q.push_back({1'b0, payload[i]});
      s = s + int'(payload[i]);
    end
    exp_q.push_back({1'b1, 8'((256 - (s % 256)) % 256)});
    modelCount++;
    if (n > MAX_LEN) expErr++;
    for (int i = 0; i < n; i++) applyStimulus(payload[i], (i == n - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("[TB] FAIL %s drain: got %0d bytes pending want 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkBytes(input string name, input bq_t want);
    checkOutput({name, " count"}, got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), got_q[i], want[i]);
  endtask

  initial begin
    bq_t p;
    bq_t w;
    int n;

    $display("[TB] start");
    #2 nrst = 1'b0;
    #1;
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst out_data", out_data, 0);
    checkOutput("rst out_last", out_last, 0);
    checkOutput("rst in_ready", in_ready, 0);
    checkOutput("rst err_overlen", err_overlen, 0);
    checkOutput("rst frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;

    got_q.delete();
    p = '{8'h01, 8'h02, 8'h03};
    sendFrame(p);
    waitDrain("t1");
    w = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'hFA};
    checkBytes("t1", w);
    checkOutput("t1 frame_cnt", frame_cnt, 1);

    got_q.delete();
    p = '{8'h00};
    sendFrame(p);
    waitDrain("t2");
    w = '{8'hA5, 8'h00, 8'h00};
    checkBytes("t2", w);
    checkOutput("t2 frame_cnt", frame_cnt, 2);

    // This payload is exactly MAX_LEN long and ends with in_last, so it
    // must not count as truncated.
    got_q.delete();
    readyMode = 1;
    p = '{8'h10, 8'h20, 8'h30, 8'h40};
    sendFrame(p);
    waitDrain("t3");
    readyMode = 0;
    w = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
    checkBytes("t3", w);
    checkOutput("t3 err pulses", errSeen, 0);

    got_q.delete();
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    sendFrame(p);
    waitDrain("t4");
    w = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    checkBytes("t4", w);
    checkOutput("t4 err pulses", errSeen, 1);
    checkOutput("t4 err model", errSeen, expErr);

    got_q.delete();
    p = '{8'h07};
    sendFrame(p);
    waitDrain("t5");
    w = '{8'hA5, 8'h07, 8'hF9};
    checkBytes("t5", w);
    checkOutput("t5 frame_cnt", frame_cnt, 5);
    checkOutput("t5 frame_cnt model", frame_cnt, 8'(modelCount));

    // Reset in the middle of a frame, after A5 and 01 have left the block
    // and while byte 09 is held in the output register.
    got_q.delete();
    exp_q.push_back({1'b0, SOF});
    exp_q.push_back({1'b0, 8'h01});
    applyStimulus(8'h01, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6 pre bytes", got_q.size(), 2);
    @(posedge clk);
    #1;
    readyMode = 2;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h09;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6 held valid", out_valid, 1);
    checkOutput("t6 held data", out_data, 8'h09);
    #2 nrst = 1'b0;
    #1;
    checkOutput("t6 rst out_valid", out_valid, 0);
    checkOutput("t6 rst out_data", out_data, 0);
    checkOutput("t6 rst out_last", out_last, 0);
    checkOutput("t6 rst in_ready", in_ready, 0);
    checkOutput("t6 rst frame_cnt", frame_cnt, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    readyMode = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    exp_q.delete();
    got_q.delete();
    modelCount = 0;
    @(posedge clk);
    #1;
    p = '{8'h02};
    sendFrame(p);
    waitDrain("t6");
    w = '{8'hA5, 8'h02, 8'hFE};
    checkBytes("t6", w);
    checkOutput("t6 frame_cnt", frame_cnt, 1);

    // Send single-byte frames back to back until the counter wraps.
    while (modelCount != 255) begin
      p = '{8'(modelCount)};
      sendFrame(p);
    end
    waitDrain("t7");
    checkOutput("t7 frame_cnt ff", frame_cnt, 8'hFF);
    p = '{8'h5A};
    sendFrame(p);
    waitDrain("t7b");
    checkOutput("t7 frame_cnt wrap", frame_cnt, 8'h00);
    checkOutput("t7 frame_cnt model", frame_cnt, 8'(modelCount));
    checkOutput("t7 err model", errSeen, expErr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
